// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and Z/N/C/V flags.
// Operations are accepted over in_valid/in_ready. Results are returned over out_valid/out_ready.
// Optional feature macro: ALU_MUL_EN builds the iterative shift-add unsigned multiplier (op 110).
// Without the macro, op 110 behaves like the reserved op: one cycle, result 0.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow
);

   localparam logic [2:0] OpAnd = 3'b000;
   localparam logic [2:0] OpOr  = 3'b001;
   localparam logic [2:0] OpAdd = 3'b010;
   localparam logic [2:0] OpSub = 3'b011;
   localparam logic [2:0] OpSlt = 3'b100;
   localparam logic [2:0] OpXor = 3'b101;

`ifdef ALU_MUL_EN
   localparam logic [2:0] OpMul = 3'b110;
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`else
   typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_sum;
   logic [WIDTH-1:0]   op_res;
   logic               op_c;
   logic               op_v;

`ifdef ALU_MUL_EN
   // Accumulator and multiplicand are double width so the high product half feeds Carry.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               is_mul;

   assign is_mul  = (ALUControl == OpMul);
   assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

   assign in_ready  = rst_n && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
   assign out_valid = (state_q == StDone);
   assign accept    = in_valid && in_ready;

   // Subtraction is A + ~B + 1, so its carry-out means no borrow (A >= B unsigned).
   assign add_sum = {1'b0, SrcA} + {1'b0, SrcB};
   assign sub_sum = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};

   // Single-cycle datapath: result plus the carry and overflow flags for the presented op.
   always_comb begin
      op_res = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      case (ALUControl)
         OpAnd: op_res = SrcA & SrcB;
         OpOr:  op_res = SrcA | SrcB;
         OpXor: op_res = SrcA ^ SrcB;
         OpAdd: begin
            op_res = add_sum[WIDTH-1:0];
            op_c   = add_sum[WIDTH];
            op_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OpSub: begin
            op_res = sub_sum[WIDTH-1:0];
            op_c   = sub_sum[WIDTH];
            op_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                     (sub_sum[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OpSlt: op_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         // Reserved op, and MUL when the multiplier is not built, produce zero.
         default: op_res = '0;
      endcase
   end

   // Next-state logic: FSM sequencing, multiplier iteration and result capture.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
`endif

      case (state_q)
         StIdle: ;
`ifdef ALU_MUL_EN
         // One multiplier bit per cycle; the final step writes the product straight to DONE.
         StCalc: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d  = StDone;
               result_d = acc_sum[WIDTH-1:0];
               zero_d   = (acc_sum[WIDTH-1:0] == '0);
               neg_d    = acc_sum[WIDTH-1];
               carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
               ovf_d    = 1'b0;
            end
         end
`endif
         StDone: if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // A new accept overrides DONE -> IDLE; in_ready keeps this out of CALC.
      if (accept) begin
`ifdef ALU_MUL_EN
         if (is_mul) begin
            state_d  = StCalc;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, SrcA};
            mplier_d = SrcB;
            cnt_d    = CntW'(WIDTH - 1);
         end else begin
`else
         begin
`endif
            state_d  = StDone;
            result_d = op_res;
            zero_d   = (op_res == '0);
            neg_d    = op_res[WIDTH-1];
            carry_d  = op_c;
            ovf_d    = op_v;
         end
      end
   end

   // State and result registers with synchronous active-low reset; reset aborts any op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
`ifdef ALU_MUL_EN
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign Negative  = neg_q;
   assign Carry     = carry_q;
   assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8). Flags are compared as {Z,N,C,V}.
module tb_alu_seq;

   localparam int unsigned W = 8;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] fl;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic [2:0]   alu_ctl = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] alu_res;
   logic         zero, negative, carry, overflow;
   logic [3:0]   fl;

   int checks = 0;
   int errors = 0;

   assign fl = {zero, negative, carry, overflow};

   alu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .SrcA       (src_a),
      .SrcB       (src_b),
      .ALUControl (alu_ctl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (alu_res),
      .Zero       (zero),
      .Negative   (negative),
      .Carry      (carry),
      .Overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      alu_ctl  = o;
      src_a    = x;
      src_b    = y;
      in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(3'b010, 8'd200, 8'd100);
      step();
      step();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (alu_res !== 8'h00) begin
         errors++;
         $display("FAIL reset_result got %h want 00", alu_res);
      end
      checks++;
      if (fl !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", fl);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready_low got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_out_valid got %b want 0", out_valid);
      end
      step();
   endtask

   task automatic test_single_cycle();
      vec_t v[12];
      v[0]  = '{3'b010, 8'd200, 8'd100, 8'h2C, 4'b0010};
      v[1]  = '{3'b011, 8'd100, 8'd76,  8'h18, 4'b0010};
      v[2]  = '{3'b011, 8'h80,  8'h01,  8'h7F, 4'b0011};
      v[3]  = '{3'b011, 8'd5,   8'd5,   8'h00, 4'b1010};
      v[4]  = '{3'b011, 8'h01,  8'h02,  8'hFF, 4'b0100};
      v[5]  = '{3'b010, 8'h7F,  8'h01,  8'h80, 4'b0101};
      v[6]  = '{3'b100, 8'hFB,  8'h03,  8'h01, 4'b0000};
      v[7]  = '{3'b100, 8'h03,  8'hFB,  8'h00, 4'b1000};
      v[8]  = '{3'b101, 8'hF0,  8'hFF,  8'h0F, 4'b0000};
      v[9]  = '{3'b111, 8'hAB,  8'hCD,  8'h00, 4'b1000};
      v[10] = '{3'b000, 8'hF3,  8'h3C,  8'h30, 4'b0000};
      v[11] = '{3'b001, 8'h81,  8'h02,  8'h83, 4'b0100};
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(v[i].op, v[i].a, v[i].b);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_valid[%0d] got %b want 0", i, out_valid);
         end
         step();
         in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency[%0d] got %b want 1", i, out_valid);
         end
         checks++;
         if (alu_res !== v[i].res) begin
            errors++;
            $display("FAIL single_result[%0d] got %h want %h", i, alu_res, v[i].res);
         end
         checks++;
         if (fl !== v[i].fl) begin
            errors++;
            $display("FAIL single_flags[%0d] got %b want %b", i, fl, v[i].fl);
         end
         step();
      end
   endtask

   task automatic test_mul();
      vec_t v[2];
`ifdef ALU_MUL_EN
      v[0] = '{3'b110, 8'd13, 8'd11, 8'h8F, 4'b0100};
      v[1] = '{3'b110, 8'd16, 8'd16, 8'h00, 4'b1010};
`else
      v[0] = '{3'b110, 8'd13, 8'd11, 8'h00, 4'b1000};
      v[1] = '{3'b110, 8'd16, 8'd16, 8'h00, 4'b1000};
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(v[i].op, v[i].a, v[i].b);
         step();
         in_valid = 1'b0;
`ifdef ALU_MUL_EN
         // Accepted at edge N; busy after edges N..N+W-1, result after edge N+W.
         for (int k = 0; k < int'(W); k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL mul_busy[%0d][%0d] got valid=%b ready=%b want 0/0",
                        i, k, out_valid, in_ready);
            end
            step();
         end
`endif
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_done_valid[%0d] got %b want 1", i, out_valid);
         end
         checks++;
         if (alu_res !== v[i].res) begin
            errors++;
            $display("FAIL mul_result[%0d] got %h want %h", i, alu_res, v[i].res);
         end
         checks++;
         if (fl !== v[i].fl) begin
            errors++;
            $display("FAIL mul_flags[%0d] got %b want %b", i, fl, v[i].fl);
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(3'b000, 8'h03, 8'h81);
      step();
      // Presented but must be ignored while stalled.
      drive(3'b101, 8'hF0, 8'hFF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || alu_res !== 8'h01 || fl !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b res=%h fl=%b want 1/01/0000",
                     k, out_valid, alu_res, fl);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      drive(3'b001, 8'hAA, 8'h55);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready got %b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || alu_res !== 8'hFF || fl !== 4'b0100) begin
         errors++;
         $display("FAIL bp_next_result got valid=%b res=%h fl=%b want 1/ff/0100",
                  out_valid, alu_res, fl);
      end
      step();
   endtask

   task automatic test_back_to_back();
      vec_t v[3];
      v[0] = '{3'b010, 8'h01, 8'h02, 8'h03, 4'b0000};
      v[1] = '{3'b011, 8'h09, 8'h04, 8'h05, 4'b0010};
      v[2] = '{3'b101, 8'hAA, 8'hAA, 8'h00, 4'b1000};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(v[i].op, v[i].a, v[i].b);
         step();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || alu_res !== v[i].res || fl !== v[i].fl) begin
            errors++;
            $display("FAIL b2b_result[%0d] got valid=%b res=%h fl=%b want 1/%h/%b",
                     i, out_valid, alu_res, fl, v[i].res, v[i].fl);
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_abort();
      out_ready = 1'b1;
`ifdef ALU_MUL_EN
      drive(3'b110, 8'd13, 8'd11);
      step();
      in_valid = 1'b0;
      step();
      step();
`else
      out_ready = 1'b0;
      drive(3'b010, 8'd200, 8'd100);
      step();
      in_valid = 1'b0;
`endif
      rst_n = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || alu_res !== 8'h00 || fl !== 4'b0000) begin
         errors++;
         $display("FAIL abort_cleared got valid=%b res=%h fl=%b want 0/00/0000",
                  out_valid, alu_res, fl);
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_ready got %b want 1", in_ready);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result[%0d] got %b want 0", k, out_valid);
         end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
